// File: rtl/pio_osr.sv
// Output shift register for one PIO state machine: holds the word being shifted out
// to X/Y/pins/PC/ISR, handles PULL, autopull refill, MOV-to-OSR and stall requests.
module pio_osr (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        penable,
   input  logic        stalled,
   input  logic        shift_dir,
   input  logic        auto_pull,
   input  logic [4:0]  pull_thresh,
   input  logic        do_out,
   input  logic [4:0]  out_count,
   input  logic        do_pull,
   input  logic        pull_block,
   input  logic        pull_ifempty,
   input  logic        mov_set,
   input  logic [31:0] mov_din,
   input  logic [31:0] x_val,
   input  logic        fifo_empty,
   input  logic [31:0] fifo_dout,
   output logic        fifo_pop,
   output logic [31:0] dout,
   output logic        osr_stall,
   output logic [31:0] osr_val,
   output logic [5:0]  shift_count
);

   logic [31:0] r_osr;
   logic [5:0]  r_count;

   logic [5:0]  w_n;
   logic [5:0]  w_thresh;
   logic        w_full;
   logic        w_act;
   logic        w_mov;
   logic        w_pull;
   logic        w_out;
   logic        w_pull_noop;
   logic        w_pull_fifo;
   logic        w_pull_stall;
   logic        w_pull_x;
   logic        w_out_stall;
   logic        w_out_exec;
   logic        w_refill;
   logic [6:0]  w_sum;
   logic [5:0]  w_count_sat;
   logic [31:0] w_mask;
   logic [31:0] w_shifted;

   // A zero count field encodes a full 32-bit transfer.
   assign w_n      = (out_count == 5'd0)   ? 6'd32 : {1'b0, out_count};
   assign w_thresh = (pull_thresh == 5'd0) ? 6'd32 : {1'b0, pull_thresh};
   assign w_full   = (r_count >= w_thresh);
   assign w_act    = penable & ~stalled;

   // Strobes are meant to be exclusive; resolve overlaps as MOV > PULL > OUT.
   assign w_mov  = w_act & mov_set;
   assign w_pull = w_act & do_pull & ~mov_set;
   assign w_out  = w_act & do_out & ~mov_set & ~do_pull;

   assign w_pull_noop  = (auto_pull | pull_ifempty) & ~w_full;
   assign w_pull_fifo  = w_pull & ~w_pull_noop & ~fifo_empty;
   assign w_pull_stall = w_pull & ~w_pull_noop & fifo_empty & pull_block;
   assign w_pull_x     = w_pull & ~w_pull_noop & fifo_empty & ~pull_block;

   assign w_out_stall = w_out & auto_pull & w_full;
   assign w_out_exec  = w_out & ~w_out_stall;

   // Refill runs in the background, even while the sequencer is stalled elsewhere.
   assign w_refill = penable & auto_pull & w_full & ~fifo_empty & ~w_mov & ~w_pull;

   assign fifo_pop  = w_pull_fifo | w_refill;
   assign osr_stall = w_out_stall | w_pull_stall;

   // Shifting a 32-bit value by 32 yields zero, which gives the n=32 cases for free.
   assign w_mask    = ~(32'hFFFF_FFFF << w_n);
   assign dout      = shift_dir ? (r_osr & w_mask) : (r_osr >> (6'd32 - w_n));
   assign w_shifted = shift_dir ? (r_osr >> w_n) : (r_osr << w_n);

   assign w_sum       = {1'b0, r_count} + {1'b0, w_n};
   assign w_count_sat = (w_sum > 7'd32) ? 6'd32 : w_sum[5:0];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_osr   <= 32'd0;
         r_count <= 6'd32;
      end else if (w_mov) begin
         r_osr   <= mov_din;
         r_count <= 6'd0;
      end else if (w_pull_fifo | w_refill) begin
         r_osr   <= fifo_dout;
         r_count <= 6'd0;
      end else if (w_pull_x) begin
         r_osr   <= x_val;
         r_count <= 6'd0;
      end else if (w_out_exec) begin
         r_osr   <= w_shifted;
         r_count <= w_count_sat;
      end
   end

   assign osr_val     = r_osr;
   assign shift_count = r_count;

endmodule
